// File: rtl/gray_pkg.sv
// Shared Gray/binary helpers for the dual-clock FIFO pointer controllers.
// Both conversion functions work on a MAX_W-bit word; narrower pointers are
// zero-extended on the way in and truncated on the way out. Leading zeros
// are neutral under both conversions, so one function serves every width.
package gray_pkg;

  localparam int MAX_W = 32;
  localparam int WIDTH = 4;

  // Pointer type for the default depth: address bits plus one wrap bit.
  typedef logic [WIDTH:0] ptr_t;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR running down from the MSB.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_fifo_read_ctrl_if.sv
// Read-side bus of the dual-clock FIFO pointer controller.
// Handshake: a dequeue is accepted on a rising CLK edge where deq__ENA and
// deq__RDY are both 1. deq__RDY depends only on controller state, never on
// deq__ENA. deq__ENA with deq__RDY low is ignored. raddr, rptrGray and count
// move on the accepting edge.
interface gray_fifo_read_ctrl_if #(parameter int width = 4);

  logic [width:0]   wptrGray;
  logic             deq__ENA;
  logic             deq__RDY;
  logic [width-1:0] raddr;
  logic [width:0]   rptrGray;
  logic [width:0]   count;
  logic             err;

  // The consumer side: drives the dequeue request and the writer's pointer.
  modport master (
    output wptrGray, deq__ENA,
    input  deq__RDY, raddr, rptrGray, count, err
  );

  // The controller side.
  modport slave (
    input  wptrGray, deq__ENA,
    output deq__RDY, raddr, rptrGray, count, err
  );

endinterface

// File: rtl/gray_sync_2ff.sv
// Generic N-bit two-flop synchronizer with asynchronous active-low reset.
// Intended for Gray-coded buses, where at most one bit moves per update.
module gray_sync_2ff #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] sync1_d, sync1_q;
  logic [N-1:0] sync2_d, sync2_q;

  // Next values: the first stage samples the foreign bus, the second the first stage.
  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  // Two-stage capture, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/gray_fifo_read_ctrl.sv
// Read-side pointer controller of a dual-clock FIFO. Synchronizes and decodes
// the writer's Gray pointer, keeps the read pointer in binary and Gray form,
// offers the dequeue handshake and occupancy, and latches a sticky error on
// multi-bit write-pointer jumps or impossible occupancy.
module gray_fifo_read_ctrl
  import gray_pkg::*;
#(
  parameter int width = 4
) (
  input logic                  CLK,
  input logic                  nRST,
  gray_fifo_read_ctrl_if.slave bus
);

  localparam int PW = width + 1;
  localparam logic [width:0] ONE = {{width{1'b0}}, 1'b1};

  logic [width:0] wsync2;
  logic [width:0] wbin;
  logic [width:0] count_w;
  logic [width:0] rbin_inc;
  logic [width:0] wdelta;
  logic           rdy;
  logic           fire;
  logic           multi_bit;
  logic           overfill;

  logic [width:0] rbin_d, rbin_q;
  logic [width:0] rptr_gray_d, rptr_gray_q;
  logic [width:0] wprev_d, wprev_q;
  logic           err_d, err_q;

  gray_sync_2ff #(.N(PW)) u_wsync (
    .clk   (CLK),
    .rst_n (nRST),
    .d     (bus.wptrGray),
    .q     (wsync2)
  );

  // Decode, empty/occupancy, dequeue acceptance, error detection, next state.
  always_comb begin
    wbin      = PW'(gray2bin(MAX_W'(wsync2)));
    // Empty is a Gray compare so it never depends on the decode path.
    rdy       = (wsync2 != rptr_gray_q);
    fire      = bus.deq__ENA & rdy;
    count_w   = wbin - rbin_q;
    rbin_inc  = rbin_q + ONE;
    // Any set bit left after clearing the lowest one means a multi-bit change.
    wdelta    = wsync2 ^ wprev_q;
    multi_bit = |(wdelta & (wdelta - ONE));
    // count above 2^width: wrap bit set together with any lower bit.
    overfill  = count_w[width] & (|count_w[width-1:0]);

    rbin_d      = rbin_q;
    rptr_gray_d = rptr_gray_q;
    if (fire) begin
      rbin_d      = rbin_inc;
      rptr_gray_d = PW'(bin2gray(MAX_W'(rbin_inc)));
    end
    wprev_d = wsync2;
    err_d   = err_q | multi_bit | overfill;
  end

  // Pointer, previous-sample and sticky error registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rbin_q      <= '0;
      rptr_gray_q <= '0;
      wprev_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      rbin_q      <= rbin_d;
      rptr_gray_q <= rptr_gray_d;
      wprev_q     <= wprev_d;
      err_q       <= err_d;
    end
  end

  assign bus.deq__RDY = rdy;
  assign bus.raddr    = rbin_q[width-1:0];
  assign bus.rptrGray = rptr_gray_q;
  assign bus.count    = count_w;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_gray_fifo_read_ctrl.sv
// Bench for gray_fifo_read_ctrl (width=4): directed scenarios plus a random
// writer/reader run, all compared against a pointer-arithmetic reference model.
module tb_gray_fifo_read_ctrl;

  localparam int W    = 4;
  localparam int PMSK = (1 << (W + 1)) - 1;  // pointer modulus - 1
  localparam int AMSK = (1 << W) - 1;
  localparam int DEPTH = 1 << W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  gray_fifo_read_ctrl_if #(.width(W)) bus ();

  gray_fifo_read_ctrl #(.width(W)) dut (
    .CLK  (clk),
    .nRST (n_rst),
    .bus  (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];   // expected raddr of each accepted dequeue

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Writer pointer as seen through the two-stage synchronizer (Gray values),
  // the previous synchronized value, the number of reads done, and the error.
  int m_s1, m_s2, m_prev, m_rd;
  bit m_err;
  int w_ptr;

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) & PMSK;
  endfunction

  function automatic int from_gray(input int g);
    int b = 0;
    for (int s = 0; s <= W; s++) b ^= (g >> s);
    return b & PMSK;
  endfunction

  function automatic int m_count();
    return (from_gray(m_s2) - m_rd) & PMSK;
  endfunction

  function automatic bit m_rdy();
    return from_gray(m_s2) != m_rd;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_prev = 0; m_rd = 0; m_err = 1'b0;
  endtask

  task automatic model_step();
    bit fire;
    if (!n_rst) begin
      model_reset();
      return;
    end
    fire = bus.deq__ENA && m_rdy();
    if (fire) exp_q.push_back(m_rd[W-1:0]);
    if ($countones(m_s2 ^ m_prev) > 1 || m_count() > DEPTH) m_err = 1'b1;
    m_prev = m_s2;
    m_s2   = m_s1;
    m_s1   = int'(bus.wptrGray);
    if (fire) m_rd = (m_rd + 1) & PMSK;
  endtask

  task automatic check_outputs();
    check_eq("count",    bus.count,    m_count());
    check_eq("deq_rdy",  bus.deq__RDY, m_rdy());
    check_eq("raddr",    bus.raddr,    m_rd & AMSK);
    check_eq("rptrGray", bus.rptrGray, to_gray(m_rd));
    check_eq("err",      bus.err,      m_err);
  endtask

  // ---------------- driver tasks ----------------
  // One clock: note whether the DUT will accept, advance the model on the
  // edge, then compare on the falling edge.
  task automatic tick();
    bit dut_fire;
    logic [W-1:0] dut_addr;
    dut_fire = bus.deq__ENA && bus.deq__RDY;
    dut_addr = bus.raddr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    if (dut_fire) begin
      if (exp_q.size() == 0) check_eq("deq_unexpected", dut_fire, 0);
      else check_eq("deq_addr", dut_addr, exp_q.pop_front());
    end
    check_eq("deq_pending", exp_q.size(), 0);
  endtask

  task automatic set_w(input int b);
    w_ptr = b & PMSK;
    bus.wptrGray = (W+1)'(to_gray(w_ptr));
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    bus.deq__ENA = 1'b0;
    set_w(0);
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  task automatic deq_n(input int n);
    bus.deq__ENA = 1'b1;
    for (int i = 0; i < n; i++) tick();
    bus.deq__ENA = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    w_ptr = 0;
    n_rst = 1'b0;
    bus.deq__ENA = 1'b0;
    bus.wptrGray = 5'b10101;

    // Reset held with a nonzero writer pointer, then released.
    tick();
    tick();
    check_eq("rst_count", bus.count, 0);
    check_eq("rst_rdy", bus.deq__RDY, 0);
    n_rst = 1'b1;
    tick();
    tick();
    check_eq("rel_count", bus.count, 25);
    check_eq("rel_rdy", bus.deq__RDY, 1);

    // Single entry.
    do_reset();
    set_w(1);
    tick();
    tick();
    check_eq("single_count", bus.count, 1);
    check_eq("single_rdy", bus.deq__RDY, 1);
    deq_n(1);
    check_eq("single_raddr", bus.raddr, 1);
    check_eq("single_rptr", bus.rptrGray, 1);
    check_eq("single_empty", bus.deq__RDY, 0);

    // Fill to full, drain, twice around the pointer space.
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin set_w(i); tick(); end
    tick();
    tick();
    check_eq("full_count", bus.count, DEPTH);
    check_eq("full_rdy", bus.deq__RDY, 1);
    check_eq("full_err", bus.err, 0);
    deq_n(DEPTH);
    check_eq("drain1_raddr", bus.raddr, 0);
    check_eq("drain1_rptr", bus.rptrGray, 5'b11000);
    check_eq("drain1_count", bus.count, 0);
    for (int i = DEPTH + 1; i <= 2 * DEPTH; i++) begin set_w(i); tick(); end
    tick();
    tick();
    check_eq("full2_count", bus.count, DEPTH);
    deq_n(DEPTH);
    check_eq("drain2_rptr", bus.rptrGray, 0);
    check_eq("drain2_raddr", bus.raddr, 0);

    // Dequeue requests while empty are ignored.
    deq_n(5);
    check_eq("empty_count", bus.count, 0);
    check_eq("empty_err", bus.err, 0);

    // Random writer and reader; writer never overfills.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 1) == 1 && ((w_ptr - m_rd) & PMSK) < DEPTH) set_w(w_ptr + 1);
      bus.deq__ENA = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.deq__ENA = 1'b0;
    check_eq("rand_err", bus.err, 0);

    // Gray violation: two bits change at once; err sticks until reset.
    do_reset();
    bus.wptrGray = 5'b00011;
    tick();
    tick();
    tick();
    check_eq("viol_err", bus.err, 1);
    bus.wptrGray = 5'b00010;
    tick();
    tick();
    bus.wptrGray = 5'b00110;
    tick();
    tick();
    tick();
    check_eq("viol_sticky", bus.err, 1);
    do_reset();
    check_eq("viol_cleared", bus.err, 0);

    // Asynchronous reset between clock edges.
    set_w(9);
    tick();
    tick();
    tick();
    deq_n(2);
    check_eq("mid_count", bus.count, 7);
    check_eq("mid_raddr", bus.raddr, 2);
    #2;
    n_rst = 1'b0;
    #1;
    check_eq("async_count", bus.count, 0);
    check_eq("async_raddr", bus.raddr, 0);
    check_eq("async_rptr", bus.rptrGray, 0);
    check_eq("async_rdy", bus.deq__RDY, 0);
    check_eq("async_err", bus.err, 0);
    model_reset();
    set_w(0);
    tick();
    n_rst = 1'b1;
    tick();
    tick();
    tick();
    check_eq("post_rdy", bus.deq__RDY, 0);

    check_eq("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
